tt_scanner: RTL and testbench

TT_SCANNER -- requirements
Module: tt_scanner

---
 rtl/var2_pkg.sv | 29 ++
 rtl/tt_delay_line.sv | 42 ++++
 rtl/tt_scanner.sv | 145 ++++++++++++++
 tb/tb_tt_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/var2_pkg.sv
// Shared types and constants for the truth-table scanner and its capture delay line.
package var2_pkg;

  localparam int unsigned VEC_W = 5;
  localparam int unsigned TT_W  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [TT_W-1:0]  EXPECTED_TT = 32'hB0B0B000;
  localparam logic [VEC_W-1:0] VEC_MAX     = '1;
  localparam logic [CNT_W-1:0] ONES_MAX    = CNT_W'(TT_W);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDrain,
    StDone
  } scan_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [VEC_W-1:0] lowest_set(input logic [TT_W-1:0] v);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (v[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tt_delay_line.sv
// Shift register carrying a valid flag and a vector index, so each result from the
// external evaluator can be matched to the vector that produced it.
module tt_delay_line #(
  parameter int unsigned Depth = 3,
  parameter int unsigned IdxW  = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [IdxW-1:0] idx_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [Depth-1:0]           valid_q, valid_d;
  logic [Depth-1:0][IdxW-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = valid_i;
    idx_d[0]   = idx_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign idx_o   = idx_q[Depth-1];

endmodule

// File: rtl/tt_scanner.sv
// Sweeps a 5-input evaluator over all 32 vectors and captures its truth table.
// Define TT_SCAN_SELFCHECK_EN to compare the captured table against EXPECTED.
module tt_scanner
  import var2_pkg::*;
#(
  parameter int unsigned      LATENCY  = 2,
  parameter logic [TT_W-1:0]  EXPECTED = EXPECTED_TT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [VEC_W-1:0]  vec,
  input  logic              eval_out,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   truth,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              match,
  output logic [VEC_W-1:0]  mismatch_idx
);

  scan_state_e       state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [TT_W-1:0]   truth_q, truth_d;
  logic [CNT_W-1:0]  ones_q, ones_d;

  logic              accept;
  logic              push_valid;
  logic              cap_valid;
  logic [VEC_W-1:0]  cap_idx;
  logic              last_cap;

  assign accept = (state_q == StIdle) && start;

  // A tag enters the delay line on the same edge its vector is driven onto vec.
  assign push_valid = accept || ((state_q == StDrive) && (vec_q != VEC_MAX));
  assign last_cap   = cap_valid && (cap_idx == VEC_MAX);

  tt_delay_line #(
    .Depth (LATENCY + 1),
    .IdxW  (VEC_W)
  ) u_delay (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (push_valid),
    .idx_i   (vec_d),
    .valid_o (cap_valid),
    .idx_o   (cap_idx)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    truth_d = truth_q;
    ones_d  = ones_q;

    unique case (state_q)
      StIdle: begin
        vec_d = '0;
        if (start) begin
          state_d = StDrive;
          truth_d = '0;
          ones_d  = '0;
        end
      end
      StDrive: begin
        if (vec_q == VEC_MAX) begin
          state_d = StDrain;
        end else begin
          vec_d = vec_q + VEC_W'(1);
        end
      end
      StDrain: begin
        if (last_cap) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        vec_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (cap_valid) begin
      truth_d[cap_idx] = eval_out;
      if (eval_out && (ones_q != ONES_MAX)) ones_d = ones_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      truth_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      truth_q <= truth_d;
      ones_q  <= ones_d;
    end
  end

`ifdef TT_SCAN_SELFCHECK_EN
  logic             match_q, match_d;
  logic [VEC_W-1:0] midx_q, midx_d;

  // Verdict is taken from the table as it stands after the final capture.
  always_comb begin
    match_d = match_q;
    midx_d  = midx_q;
    if (accept) begin
      match_d = 1'b0;
      midx_d  = '0;
    end else if (last_cap) begin
      match_d = (truth_d == EXPECTED);
      midx_d  = lowest_set(truth_d ^ EXPECTED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      midx_q  <= '0;
    end else begin
      match_q <= match_d;
      midx_q  <= midx_d;
    end
  end

  assign match        = match_q;
  assign mismatch_idx = midx_q;
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
  assign match           = 1'b0;
  assign mismatch_idx    = '0;
`endif

  assign vec      = vec_q;
  assign busy     = (state_q == StDrive) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign truth    = truth_q;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench: two scanners (LATENCY 2 and 4) driven in lockstep against
// behavioural evaluator pipelines, with table-driven sweeps plus reset/start corners.
module tb_tt_scanner;
  import var2_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [4:0]  vec2, vec4, midx2, midx4;
  logic        eval2, eval4, busy2, busy4, done2, done4, match2, match4;
  logic [31:0] truth2, truth4;
  logic [5:0]  ones2, ones4;

  tt_scanner #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec2), .eval_out(eval2), .busy(busy2),
    .done(done2), .truth(truth2), .ones_cnt(ones2), .match(match2), .mismatch_idx(midx2)
  );

  tt_scanner #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .vec(vec4), .eval_out(eval4), .busy(busy4),
    .done(done4), .truth(truth4), .ones_cnt(ones4), .match(match4), .mismatch_idx(midx4)
  );

  // Evaluator modes: 0 golden, 1 in[0] stuck at 0, 2 output stuck 1, 3 output stuck 0.
  int mode = 0;

  function automatic logic f_eval(input int m, input logic [4:0] v);
    logic [4:0] x;
    x = v;
    if (m == 1) x[0] = 1'b0;
    if (m == 2) return 1'b1;
    if (m == 3) return 1'b0;
    return (x[4] | x[3]) & x[2] & (~x[1] | x[0]);
  endfunction

  logic [1:0] p2 = '0;
  logic [3:0] p4 = '0;
  always @(posedge clk) begin
    p2 <= {p2[0], f_eval(mode, vec2)};
    p4 <= {p4[2:0], f_eval(0, vec4)};
  end
  assign eval2 = p2[1];
  assign eval4 = p4[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sc(input logic b);
`ifdef TT_SCAN_SELFCHECK_EN
    return b;
`else
    return 1'b0 & b;
`endif
  endfunction

  function automatic logic [4:0] sc5(input logic [4:0] v);
`ifdef TT_SCAN_SELFCHECK_EN
    return v;
`else
    return 5'd0 & v;
`endif
  endfunction

  typedef struct {
    int          mode;
    logic [31:0] tt;
    logic [5:0]  ones;
    logic        m;
    logic [4:0]  idx;
  } vec_t;

  vec_t tbl[4];

  task automatic sweep(input int hold, input vec_t r);
    int n, n2, n4, nd2, nd4, acc2;
    logic busy_prev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0; n2 = -1; n4 = -1; nd2 = 0; nd4 = 0; acc2 = 1; busy_prev = 1'b1;
    while (n < 80) begin
      @(negedge clk);
      if (n + 1 >= hold) start = 1'b0;
      if (n == 0) begin
        chk("busy_on_accept", 32'(busy2), 32'd1);
        chk("vec_first", 32'(vec2), 32'd0);
        chk("truth_cleared", truth2, 32'd0);
        chk("ones_cleared", 32'(ones2), 32'd0);
      end
      if (n == 5)  chk("vec_step", 32'(vec2), 32'd5);
      if (n == 31) chk("vec_last", 32'(vec2), 32'd31);
      if (n == 33) chk("vec_drain_hold", 32'(vec2), 32'd31);
      if (busy2 && !busy_prev) acc2++;
      busy_prev = busy2;
      if (done2) begin
        nd2++;
        if (n2 < 0) begin
          n2 = n;
          chk("busy_low_at_done", 32'(busy2), 32'd0);
          chk("truth_at_done", truth2, r.tt);
          chk("ones_at_done", 32'(ones2), 32'(r.ones));
          chk("match_at_done", 32'(match2), 32'(sc(r.m)));
          chk("midx_at_done", 32'(midx2), 32'(sc5(r.idx)));
        end
      end
      if (done4) begin
        nd4++;
        if (n4 < 0) n4 = n;
      end
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_time_lat2", n2, 32'd34);
    chk("done_time_lat4", n4, 32'd36);
    chk("done_pulses_lat2", nd2, 32'd1);
    chk("done_pulses_lat4", nd4, 32'd1);
    chk("sweep_count", acc2, 32'd1);
    chk("vec_idle", 32'(vec2), 32'd0);
    chk("truth_held", truth2, r.tt);
    chk("ones_held", 32'(ones2), 32'(r.ones));
    chk("match_held", 32'(match2), 32'(sc(r.m)));
    chk("midx_held", 32'(midx2), 32'(sc5(r.idx)));
    chk("truth_lat4", truth4, 32'hB0B0B000);
    chk("ones_lat4", 32'(ones4), 32'd9);
    chk("match_lat4", 32'(match4), 32'(sc(1'b1)));
  endtask

  initial begin
    int nd;
    tbl[0] = '{mode: 0, tt: 32'hB0B0B000, ones: 6'd9,  m: 1'b1, idx: 5'd0};
    tbl[1] = '{mode: 1, tt: 32'h30303000, ones: 6'd6,  m: 1'b0, idx: 5'd15};
    tbl[2] = '{mode: 2, tt: 32'hFFFFFFFF, ones: 6'd32, m: 1'b0, idx: 5'd0};
    tbl[3] = '{mode: 3, tt: 32'h00000000, ones: 6'd0,  m: 1'b0, idx: 5'd12};

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", 32'(vec2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_truth", truth2, 32'd0);
    chk("rst_ones", 32'(ones2), 32'd0);
    chk("rst_match", 32'(match2), 32'd0);
    chk("rst_midx", 32'(midx2), 32'd0);
    rst = 1'b0;

    // Abort a sweep with reset at E+10, with start also high to show reset wins.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_sweep", 32'(busy2), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_busy_lat4", 32'(busy4), 32'd0);
    chk("abort_truth", truth2, 32'd0);
    chk("abort_vec", 32'(vec2), 32'd0);
    chk("abort_ones", 32'(ones2), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done2 || done4 || busy2) nd++;
    end
    chk("abort_no_done", nd, 32'd0);

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      sweep(1, tbl[i]);
    end

    // start held across the whole sweep up to and including the DONE cycle.
    mode = 0;
    sweep(36, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
